// File: rtl/dmem_access_ctrl.sv
// Y86-64 memory-stage initiator: decodes the data access for one instruction and runs a
// single valid/ready request/response transaction to a multi-cycle data memory.
module dmem_access_ctrl #(
  parameter int ADDR_LIMIT     = 258,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  localparam logic [63:0] ADDR_LIM = 64'(ADDR_LIMIT);
  localparam logic [7:0]  TIMEOUT  = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        req_q;
  logic        we_q;
  logic        done_q;
  logic        err_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] valm_q;

  logic        is_wr;
  logic        is_rd;
  logic        is_mem;
  logic        legal;
  logic [63:0] dec_addr;
  logic [63:0] dec_wdata;

  always_comb begin
    is_wr     = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
    is_rd     = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
    is_mem    = is_wr || is_rd;
    // popq/ret address through the stack pointer carried in valA
    dec_addr  = ((icode == 4'h9) || (icode == 4'hB)) ? valA : valE;
    dec_wdata = 64'd0;
    if ((icode == 4'h4) || (icode == 4'hA)) begin
      dec_wdata = valA;
    end else if (icode == 4'h8) begin
      dec_wdata = valP;
    end
    legal     = is_mem && (dec_addr < ADDR_LIM);
    cnt_d     = cnt_q + 8'd1;
  end

  assign busy = reset_n && ((state_q == REQ) || (state_q == WAIT) ||
                            ((state_q == IDLE) && start && legal));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      valm_q  <= 64'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (legal) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              we_q    <= is_wr;
              addr_q  <= dec_addr;
              wdata_q <= dec_wdata;
              err_q   <= 1'b0;
            end else begin
              // non-memory ops finish clean, out-of-range memory ops finish in error
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= is_mem;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            req_q <= 1'b0;
            if (mem_rvalid) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= mem_err;
              if (!we_q) valm_q <= mem_rdata;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 8'd0;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= mem_err;
            if (!we_q) valm_q <= mem_rdata;
          end else if (cnt_d == TIMEOUT) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign valM       = valm_q;
  assign dmem_error = err_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_dmem_access_ctrl;

  localparam int TO  = 16;
  localparam int LIM = 258;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic        dmem_error;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  // reference model: architectural results of the last completed transaction
  logic [63:0] m_valm = 64'd0;
  logic        m_err  = 1'b0;

  dmem_access_ctrl #(.ADDR_LIMIT(LIM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .dmem_error(dmem_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // g: REQ cycles with gnt low; same: rvalid with gnt; rw: WAIT cycle index carrying rvalid
  task automatic run_txn(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, input int g, input bit same, input int rw,
                         input logic [63:0] rd, input logic merr, input bit stray_start,
                         input bit done_start);
    bit is_wr, is_rd, is_mem, legal, e_busy, e_done, e_req;
    logic [63:0] ad, wd, old_valm, new_valm, exp_valm;
    logic old_err, new_err, exp_err;
    int lat, rv_n, last;
    is_wr  = ic inside {4'h4, 4'h8, 4'hA};
    is_rd  = ic inside {4'h5, 4'h9, 4'hB};
    is_mem = is_wr || is_rd;
    ad     = (ic inside {4'h9, 4'hB}) ? a : e;
    wd     = (ic inside {4'h4, 4'hA}) ? a : ((ic == 4'h8) ? p : 64'd0);
    legal  = is_mem && (ad < 64'(LIM));
    old_valm = m_valm;
    old_err  = m_err;
    new_valm = old_valm;
    new_err  = 1'b0;
    rv_n     = -1;
    if (!is_mem) begin
      lat = 1;
    end else if (!legal) begin
      lat = 1;
      new_err = 1'b1;
    end else begin
      if (same) begin
        rv_n = 1 + g;
        lat  = rv_n + 1;
      end else begin
        rv_n = 2 + g + rw;
        lat  = (rw < TO) ? rv_n + 1 : 2 + g + TO;
      end
      if (rv_n < lat) begin
        new_err = merr;
        if (is_rd) new_valm = rd;
      end else begin
        new_err = 1'b1;
      end
    end
    last = ((rv_n > lat) ? rv_n : lat) + 2;
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      start = (n == 0) || (done_start && n == lat) || (stray_start && legal && n == 2 && n < lat - 1);
      if (n == 0) begin
        icode = ic; valE = e; valA = a; valP = p;
      end else if (start) begin
        icode = 4'h5; valE = 64'h30;
      end
      mem_gnt    = legal && (n == 1 + g);
      mem_rvalid = (n == rv_n) || (n == last) || (legal && n >= 1 && n < 1 + g && $urandom_range(0, 1) == 1);
      mem_rdata  = (n == rv_n) ? rd : {$urandom, $urandom};
      mem_err    = (n == rv_n) ? merr : 1'($urandom_range(0, 1));
      #1;
      e_busy = legal && (n < lat);
      e_done = (n == lat);
      e_req  = legal && (n >= 1) && (n <= 1 + g);
      if (n == 0) begin
        exp_valm = old_valm; exp_err = old_err;
      end else if (n < lat) begin
        exp_valm = old_valm; exp_err = 1'b0;
      end else begin
        exp_valm = new_valm; exp_err = new_err;
      end
      checks++;
      if (busy !== e_busy) begin errors++; $display("FAIL busy icode=%h n=%0d got=%b exp=%b", ic, n, busy, e_busy); end
      checks++;
      if (done !== e_done) begin errors++; $display("FAIL done icode=%h n=%0d got=%b exp=%b", ic, n, done, e_done); end
      checks++;
      if (mem_req !== e_req) begin errors++; $display("FAIL mem_req icode=%h n=%0d got=%b exp=%b", ic, n, mem_req, e_req); end
      checks++;
      if (valM !== exp_valm) begin errors++; $display("FAIL valM icode=%h n=%0d got=%h exp=%h", ic, n, valM, exp_valm); end
      checks++;
      if (dmem_error !== exp_err) begin errors++; $display("FAIL dmem_error icode=%h n=%0d got=%b exp=%b", ic, n, dmem_error, exp_err); end
      if (e_req) begin
        checks++;
        if (mem_addr !== ad) begin errors++; $display("FAIL mem_addr icode=%h n=%0d got=%h exp=%h", ic, n, mem_addr, ad); end
        checks++;
        if (mem_we !== is_wr) begin errors++; $display("FAIL mem_we icode=%h n=%0d got=%b exp=%b", ic, n, mem_we, is_wr); end
        checks++;
        if (mem_wdata !== wd) begin errors++; $display("FAIL mem_wdata icode=%h n=%0d got=%h exp=%h", ic, n, mem_wdata, wd); end
      end
    end
    start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    m_valm = new_valm;
    m_err  = new_err;
    $display("txn icode=%h addr=%h legal=%0d latency=%0d valM=%h dmem_error=%0d", ic, ad, legal, lat, new_valm, new_err);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, dmem_error, mem_req, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, dmem_error, mem_req, mem_we}); end
    checks++;
    if ({valM, mem_addr, mem_wdata} !== 192'd0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", valM, mem_addr, mem_wdata); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_valm = 64'd0; m_err = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_mrmovq();
    run_txn(4'h5, 64'h10, 64'h0, 64'h0, 1, 1'b0, 1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_call();
    run_txn(4'h8, 64'h40, 64'h77, 64'h123, 0, 1'b1, 0, 64'h5555, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal_then_ret();
    run_txn(4'hB, 64'h0, 64'h102, 64'h0, 0, 1'b0, 0, 64'h1, 1'b0, 1'b0, 1'b0);
    run_txn(4'h9, 64'h999, 64'h20, 64'h0, 2, 1'b0, 2, 64'hC0FFEE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(4'h5, 64'h18, 64'h0, 64'h0, 0, 1'b0, TO + 3, 64'hBAD, 1'b0, 1'b0, 1'b0);
    run_txn(4'h5, 64'h18, 64'h0, 64'h0, 0, 1'b0, TO - 1, 64'hABCD1234, 1'b0, 1'b0, 1'b0);
    run_txn(4'h5, 64'h18, 64'h0, 64'h0, 1, 1'b0, TO, 64'h1111, 1'b0, 1'b0, 1'b0);
    run_txn(4'h9, 64'h0, 64'h28, 64'h0, 0, 1'b0, 3, 64'h2222, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    start = 1'b1; icode = 4'h5; valE = 64'h28;
    @(negedge clk);
    start = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got=%b exp=1", busy); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    start = 1'b1; icode = 4'h5; valE = 64'h10;
    #1;
    checks++;
    if ({busy, done, dmem_error, mem_req, mem_we} !== 5'b0) begin errors++; $display("FAIL async_reset_flags got=%b exp=00000", {busy, done, dmem_error, mem_req, mem_we}); end
    checks++;
    if ({valM, mem_addr, mem_wdata} !== 192'd0) begin errors++; $display("FAIL async_reset_data got=%h/%h/%h exp=0", valM, mem_addr, mem_wdata); end
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;
    m_valm = 64'd0; m_err = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_req} !== 3'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=000", {busy, done, mem_req}); end
    $display("txn reset during WAIT");
    run_txn(4'hA, 64'h8, 64'h55, 64'h0, 1, 1'b0, 0, 64'h9, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_txn(4'h4, 64'h60, 64'hFEED, 64'h0, 5, 1'b0, 1, 64'h0, 1'b0, 1'b1, 1'b1);
    run_txn(4'h5, 64'h68, 64'h0, 64'h0, 5, 1'b1, 0, 64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_boundary();
    run_txn(4'h4, 64'd257, 64'hAA, 64'h0, 0, 1'b0, 0, 64'h0, 1'b0, 1'b0, 1'b0);
    run_txn(4'h4, 64'd258, 64'hAA, 64'h0, 0, 1'b0, 0, 64'h0, 1'b0, 1'b0, 1'b0);
    run_txn(4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 0, 1'b0, 0, 64'h3, 1'b0, 1'b0, 1'b0);
    run_txn(4'h0, 64'h10, 64'h10, 64'h10, 0, 1'b0, 0, 64'h4, 1'b0, 1'b0, 1'b1);
    run_txn(4'h6, 64'hFFFF, 64'h0, 64'h0, 0, 1'b0, 0, 64'h5, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 4))
      0, 1:    pick_addr = 64'($urandom_range(0, LIM - 1));
      2:       pick_addr = 64'(LIM - 1);
      3:       pick_addr = 64'(LIM);
      default: pick_addr = {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(4'($urandom_range(0, 15)), pick_addr(), pick_addr(), {$urandom, $urandom},
              $urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom_range(0, 20),
              {$urandom, $urandom}, 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_mrmovq();
    test_call();
    test_illegal_then_ret();
    test_timeout();
    test_reset_mid_wait();
    test_stall();
    test_boundary();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Memory-stage initiator for the Y86-64 data memory.
- Per instruction, takes icode, valE, valA and valP, and derives the access: address, write data, and read or write.
- Runs one request/response transaction over a valid/ready handshake to a multi-cycle data memory, and stalls the stage while the transaction is busy.
- Returns valM and a data-memory error flag for status generation.

Parameters:
- ADDR_LIMIT, 258, first illegal word address; any address >= ADDR_LIMIT is a dmem error and is never issued.
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before the transaction is aborted as an error; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: the stage inputs are valid; sampled only in IDLE.
- icode  in  4  instruction code.
- valE  in  64  ALU result.
- valA  in  64  register A value.
- valP  in  64  next PC.
- busy  out  1  stall request to the pipeline.
- done  out  1  one-cycle completion pulse.
- valM  out  64  loaded data.
- dmem_error  out  1  error for the last transaction.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  64  word address.
- mem_wdata  out  64  write data.
- mem_gnt  in  1  memory accepts the request.
- mem_rvalid  in  1  response valid; read data or write acknowledge.
- mem_rdata  in  64  read data.
- mem_err  in  1  memory-reported error, qualified by mem_rvalid.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; the open transaction is abandoned.
  - Every output is 0 immediately: busy, done, valM, dmem_error, mem_req, mem_we, mem_addr, mem_wdata.
- Access decode, latched on the clock edge that accepts start:
  - Write ops (icode 4, A, 8): mem_we = 1.
  - Read ops (icode 5, 9, B): mem_we = 0.
  - Any other icode: not a memory op.
  - Address: valE for icode 4, 5, A, 8; valA for icode 9, B.
  - Write data: valA for icode 4, A; valP for icode 8; 0 otherwise.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On start with a non-memory icode: go to DONE; dmem_error = 0; valM unchanged.
  - On start with address >= ADDR_LIMIT (unsigned, 64-bit compare): go to DONE; dmem_error = 1; no request issued.
  - On start with a legal memory op: go to REQ.
  - Stray mem_rvalid is ignored.
- REQ:
  - mem_req = 1; mem_addr, mem_we and mem_wdata are held stable until mem_gnt.
  - mem_gnt without mem_rvalid: go to WAIT; clear the timeout counter.
  - mem_gnt and mem_rvalid in the same cycle (zero-latency memory): complete directly and go to DONE.
  - mem_rvalid without mem_gnt is ignored.
- WAIT:
  - mem_req = 0; the 8-bit counter increments every cycle.
  - On mem_rvalid: for a read, valM <= mem_rdata; dmem_error <= mem_err; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no mem_rvalid: dmem_error <= 1; valM unchanged; go to DONE.
  - A late mem_rvalid arriving after a timeout is ignored.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- busy:
  - Combinationally high when the state is REQ or WAIT, or when in IDLE with start asserted and the op is a legal memory op.
  - Low in DONE.
- Latency:
  - Non-memory op or illegal address: done 1 cycle after start.
  - Legal op: done = 1 + (cycles until mem_gnt) + (cycles until mem_rvalid) + 1 after start.
- Hold behaviour:
  - valM and dmem_error hold their values until the next transaction updates them.
  - dmem_error is cleared when the next legal or non-memory start is accepted.
- start is ignored outside IDLE; a start in the DONE cycle is dropped.
- Writes never modify valM.

Test Plan:
- mrmovq (icode 5, valE=0x10): mem_req with addr 0x10, we=0; gnt at cycle 2, rvalid at cycle 4 with rdata 0xDEADBEEF → valM = 0xDEADBEEF, done one cycle later, busy high from start until DONE.
- call (icode 8, valE=0x40, valP=0x123): request has we=1, addr 0x40, wdata 0x123; gnt and rvalid in the same cycle → done next cycle, valM unchanged, dmem_error = 0.
- popq (icode B, valA=0x102=258): no mem_req ever; done 1 cycle after start with dmem_error = 1. Then ret (icode 9, valA=0x20) → dmem_error clears, addr 0x20.
- Read with gnt and no rvalid, TIMEOUT_CYCLES=16: done exactly 16 cycles after entering WAIT with dmem_error = 1; an rvalid injected 3 cycles later has no effect.
- Hold reset_n low in WAIT mid-transaction: all outputs 0 asynchronously, before the next edge. After release, a new start on pushq (icode A, valE=0x8, valA=0x55) completes normally with wdata 0x55.
- Stall mem_gnt low for 5 cycles in REQ: mem_addr, mem_we and mem_wdata stable throughout; a second start during REQ is ignored.
